// File: rtl/icache_if.sv
// -----------------------------------------------------------------------------
// icache_if -- Avalon-MM style instruction bus between the fetch unit and the
// instruction cache.
//
// Signals
//   read         fetch unit requests a read this cycle
//   address      byte address of the request (bits [1:0] ignored)
//   write        write request (an instruction cache ignores it)
//   writedata    write data (unused by the cache)
//   byte_enable  write byte lanes (unused by the cache)
//   waitrequest  cache is not accepting the current request
//   readdata     word returned one cycle after an accepted read
//
// Modports
//   master  fetch-unit side (drives the request, receives the response)
//   slave   cache side (receives the request, drives the response)
// -----------------------------------------------------------------------------
interface icache_if;
    logic        read;
    logic [31:0] address;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output read, address, write, writedata, byte_enable,
        input  waitrequest, readdata
    );

    modport slave (
        input  read, address, write, writedata, byte_enable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache -- direct-mapped, read-only instruction cache with pipelined refill.
//
// Parameters
//   NUM_LINES   number of lines (power of 2)
//   LINE_WORDS  32-bit words per line (power of 2, >= 2)
//
// Ports
//   clk                sole clock, all state changes on its rising edge
//   rst                synchronous active-high reset
//   icache_invalidate  one-cycle pulse that invalidates every line (fence.i)
//   ibus               slave side of the fetch bus (icache_if.slave)
//   mem_read           read request to backing memory
//   mem_address        word-aligned byte address of that request
//   mem_waitrequest    memory is not accepting the current request
//   mem_readdata       memory read data
//   mem_readdatavalid  mem_readdata is valid this cycle (in request order)
//
// A hit is answered with waitrequest low in the same cycle and the word
// appears on readdata one cycle later. A miss parks the request (waitrequest
// high), fetches the whole line with as many outstanding reads as memory
// accepts, and the held request then hits on the cycle after the last word
// lands in the RAM.
// -----------------------------------------------------------------------------
module icache #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_invalidate,
    icache_if.slave     ibus,
    output logic        mem_read,
    output logic [31:0] mem_address,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readdatavalid
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    // One extra bit so the issue counter can reach LINE_WORDS without wrapping.
    localparam int CNT_W = OFF_W + 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_next_s;

    logic [NUM_LINES-1:0] valid_r;
    logic [TAG_W-1:0]     tag_r [NUM_LINES];
    logic [31:0]          ram_r [NUM_LINES*LINE_WORDS];
    logic [31:0]          readdata_r;

    logic [TAG_W-1:0]   base_tag_r;
    logic [IDX_W-1:0]   base_idx_r;
    logic [CNT_W-1:0]   issue_cnt_r;
    logic [CNT_W-1:0]   resp_cnt_r;
    logic               inv_pend_r;

    logic [OFF_W-1:0]   req_off_s;
    logic [IDX_W-1:0]   req_idx_s;
    logic [TAG_W-1:0]   req_tag_s;
    logic               hit_s;
    logic               miss_s;
    logic               last_resp_s;
    logic               waitrequest_s;

    // Fields the cache never looks at: write side of the bus and byte offset.
    logic               unused_s;
    assign unused_s = ^{ibus.write, ibus.writedata, ibus.byte_enable, ibus.address[1:0]};

    assign req_off_s = ibus.address[2 +: OFF_W];
    assign req_idx_s = ibus.address[2 + OFF_W +: IDX_W];
    assign req_tag_s = ibus.address[31 -: TAG_W];

    // Tag lookup; only meaningful while idle with a read pending.
    always_comb begin
        hit_s  = 1'b0;
        miss_s = 1'b0;
        if ((state_r == IDLE) && ibus.read) begin
            hit_s  = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
            miss_s = !hit_s;
        end else begin
            hit_s  = 1'b0;
            miss_s = 1'b0;
        end
    end

    // The LINE_WORDS-th response of a refill closes it.
    assign last_resp_s = (state_r == REFILL) && mem_readdatavalid &&
                         (resp_cnt_r == CNT_W'(LINE_WORDS - 1));

    // Memory request side is a pure function of refill registers.
    assign mem_read    = (state_r == REFILL) && (issue_cnt_r < CNT_W'(LINE_WORDS));
    assign mem_address = {base_tag_r, base_idx_r, issue_cnt_r[OFF_W-1:0], 2'b00};

    assign ibus.waitrequest = waitrequest_s;
    assign ibus.readdata    = readdata_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state and bus stall.
    always_comb begin
        state_next_s  = state_r;
        waitrequest_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (miss_s) begin
                    waitrequest_s = 1'b1;
                    state_next_s  = REFILL;
                end else begin
                    waitrequest_s = 1'b0;
                    state_next_s  = IDLE;
                end
            end
            REFILL: begin
                waitrequest_s = 1'b1;
                if (last_resp_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = REFILL;
                end
            end
            default: begin
                waitrequest_s = 1'b1;
                state_next_s  = IDLE;
            end
        endcase
    end

    // Valid bits, refill bookkeeping and deferred invalidation.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r     <= '0;
            base_tag_r  <= '0;
            base_idx_r  <= '0;
            issue_cnt_r <= '0;
            resp_cnt_r  <= '0;
            inv_pend_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // The lookup above already used the old valid bits, so a
                    // same-cycle hit still completes.
                    if (icache_invalidate) begin
                        valid_r <= '0;
                    end
                    if (miss_s) begin
                        base_tag_r  <= req_tag_s;
                        base_idx_r  <= req_idx_s;
                        issue_cnt_r <= '0;
                        resp_cnt_r  <= '0;
                    end
                    inv_pend_r <= 1'b0;
                end
                REFILL: begin
                    if (mem_read && !mem_waitrequest) begin
                        issue_cnt_r <= issue_cnt_r + CNT_W'(1);
                    end
                    if (mem_readdatavalid) begin
                        resp_cnt_r <= resp_cnt_r + CNT_W'(1);
                    end
                    if (last_resp_s) begin
                        // An invalidate seen during the refill wins over the
                        // freshly fetched line as well.
                        if (inv_pend_r || icache_invalidate) begin
                            valid_r <= '0;
                        end else begin
                            valid_r[base_idx_r] <= 1'b1;
                        end
                        inv_pend_r <= 1'b0;
                    end else if (icache_invalidate) begin
                        inv_pend_r <= 1'b1;
                    end
                end
                default: begin
                    inv_pend_r <= 1'b0;
                end
            endcase
        end
    end

    // Tag store; guarded by the valid bits so it needs no reset.
    always_ff @(posedge clk) begin
        if (last_resp_s && !rst) begin
            tag_r[base_idx_r] <= base_tag_r;
        end
    end

    // Data RAM write port, filled in response order.
    always_ff @(posedge clk) begin
        if ((state_r == REFILL) && mem_readdatavalid && !rst) begin
            ram_r[{base_idx_r, resp_cnt_r[OFF_W-1:0]}] <= mem_readdata;
        end
    end

    // Registered RAM read port; holds its word until the next hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            readdata_r <= 32'h0000_0000;
        end else if (hit_s) begin
            readdata_r <= ram_r[{req_idx_s, req_off_s}];
        end
    end

endmodule

// File: tb/tb_icache.sv
module tb_icache;
    localparam int NUM_LINES  = 64;
    localparam int LINE_WORDS = 4;
    localparam int LINE_BYTES = LINE_WORDS * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        icache_invalidate = 1'b0;
    logic        mem_read;
    logic [31:0] mem_address;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] mem_readdata = 32'h0;
    logic        mem_readdatavalid = 1'b0;

    icache_if ibus_if ();

    icache #(.NUM_LINES(NUM_LINES), .LINE_WORDS(LINE_WORDS)) dut (
        .clk               (clk),
        .rst               (rst),
        .icache_invalidate (icache_invalidate),
        .ibus              (ibus_if),
        .mem_read          (mem_read),
        .mem_address       (mem_address),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Memory model state
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] log_addr[$];
    int          log_cyc[$];
    logic [31:0] stall_log[$];
    int          stall_at   = -1;
    int          stall_left = 0;
    bit          rnd_mode   = 1'b0;
    int          last_due   = 0;

    // Reference cache contents: which line base each index holds
    logic [31:0] model_base[NUM_LINES];
    bit          model_vld[NUM_LINES];

    typedef struct {
        logic [31:0] addr;
        bit          exp_hit;
    } vec_t;
    vec_t vecs[13];

    function automatic logic [31:0] mw(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int line_idx(input logic [31:0] a);
        return int'((a / LINE_BYTES) % NUM_LINES);
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_refill(input string name, input logic [31:0] base, input int reps);
        check({name, " req count"}, log_addr.size(), 32'(LINE_WORDS * reps));
        for (int r = 0; r < reps; r++) begin
            for (int w = 0; w < LINE_WORDS; w++) begin
                if (r * LINE_WORDS + w < log_addr.size())
                    check({name, " req addr"}, log_addr[r * LINE_WORDS + w], base + 32'(4 * w));
            end
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int inv_at,
                           output int waits, output logic [31:0] data);
        bit done;
        done  = 1'b0;
        waits = 0;
        log_addr.delete();
        log_cyc.delete();
        stall_log.delete();
        ibus_if.write   = 1'b0;
        ibus_if.read    = 1'b1;
        ibus_if.address = addr;
        for (int i = 0; i < 300; i++) begin
            icache_invalidate = (i == inv_at);
            #1;
            if (!ibus_if.waitrequest) begin
                done = 1'b1;
                break;
            end
            waits++;
            @(negedge clk);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL read timeout: addr %h never accepted", addr);
        end
        @(negedge clk);
        icache_invalidate = 1'b0;
        data = ibus_if.readdata;
    endtask

    task automatic idle(input int n);
        ibus_if.read  = 1'b0;
        ibus_if.write = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_invalidate();
        ibus_if.read      = 1'b0;
        icache_invalidate = 1'b1;
        @(negedge clk);
        icache_invalidate = 1'b0;
    endtask

    task automatic do_reset();
        ibus_if.read      = 1'b0;
        ibus_if.write     = 1'b0;
        icache_invalidate = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20 && pend_addr.size() > 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Backing memory: in-order responses, optional stalls and random latency
    initial forever begin
        int lat;
        int due;
        @(negedge clk);
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = mw(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            mem_readdatavalid = 1'b0;
            mem_readdata      = 32'h0;
        end
        if (mem_read) begin
            if (stall_left > 0 && log_addr.size() == stall_at) begin
                mem_waitrequest = 1'b1;
                stall_left--;
                stall_log.push_back(mem_address);
            end else if (rnd_mode) begin
                mem_waitrequest = ($urandom_range(0, 3) == 0);
            end else begin
                mem_waitrequest = 1'b0;
            end
            if (!mem_waitrequest) begin
                lat = rnd_mode ? int'($urandom_range(1, 3)) : 1;
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_addr.push_back(mem_address);
                pend_due.push_back(due);
                log_addr.push_back(mem_address);
                log_cyc.push_back(cyc);
            end
        end else begin
            mem_waitrequest = 1'b0;
        end
    end

    initial begin
        int          waits;
        logic [31:0] data;
        logic [31:0] a;
        logic [31:0] b;
        bit          exp_hit;
        int          r;

        vecs[0]  = '{32'h0000_0400, 1'b0};
        vecs[1]  = '{32'h0000_0404, 1'b1};
        vecs[2]  = '{32'h0000_0000, 1'b0};
        vecs[3]  = '{32'h0000_000C, 1'b1};
        vecs[4]  = '{32'h0000_0010, 1'b0};
        vecs[5]  = '{32'h0000_001C, 1'b1};
        vecs[6]  = '{32'h0000_03F0, 1'b0};
        vecs[7]  = '{32'h0000_03FC, 1'b1};
        vecs[8]  = '{32'hFFFF_FFF4, 1'b0};
        vecs[9]  = '{32'h0000_03F8, 1'b0};
        vecs[10] = '{32'h0000_0408, 1'b0};
        vecs[11] = '{32'h0000_0008, 1'b0};
        vecs[12] = '{32'h0000_0014, 1'b1};

        ibus_if.read        = 1'b0;
        ibus_if.write       = 1'b0;
        ibus_if.address     = 32'h0;
        ibus_if.writedata   = 32'h0;
        ibus_if.byte_enable = 4'h0;

        // Reset state
        do_reset();
        #1;
        check("reset readdata", ibus_if.readdata, 32'h0);
        check("reset waitrequest", 32'(ibus_if.waitrequest), 32'h0);
        check("reset mem_read", 32'(mem_read), 32'h0);

        // Cold miss on 0x0 with a zero-wait, 1-cycle memory
        @(negedge clk);
        do_read(32'h0, -1, waits, data);
        check("cold waits", waits, 32'(LINE_WORDS + 2));
        check_refill("cold", 32'h0, 1);
        for (int k = 1; k < LINE_WORDS && k < log_cyc.size(); k++)
            check("cold consecutive", log_cyc[k] - log_cyc[k - 1], 32'h1);
        check("cold data", data, mw(32'h0));

        // Back-to-back hits in the same line
        for (int k = 1; k < LINE_WORDS; k++) begin
            do_read(32'(4 * k), -1, waits, data);
            check("b2b waits", waits, 32'h0);
            check("b2b data", data, mw(32'(4 * k)));
            check("b2b no mem_read", log_addr.size(), 32'h0);
        end

        // Writes are ignored and readdata holds
        ibus_if.read    = 1'b0;
        ibus_if.write   = 1'b1;
        ibus_if.address = 32'h0000_0400;
        #1;
        check("write waitrequest", 32'(ibus_if.waitrequest), 32'h0);
        log_addr.delete();
        @(negedge clk);
        @(negedge clk);
        ibus_if.write = 1'b0;
        check("write no mem_read", log_addr.size(), 32'h0);
        check("readdata hold", ibus_if.readdata, mw(32'h0000_000C));
        do_read(32'h4, -1, waits, data);
        check("after write hit", waits, 32'h0);

        // Table-driven hit/miss sequence including conflict evictions
        for (int v = 0; v < 13; v++) begin
            do_read(vecs[v].addr, -1, waits, data);
            if (vecs[v].exp_hit) begin
                check("tbl hit waits", waits, 32'h0);
                check("tbl hit no mem_read", log_addr.size(), 32'h0);
            end else begin
                check("tbl miss waits", waits, 32'(LINE_WORDS + 2));
                check_refill("tbl miss", line_base(vecs[v].addr), 1);
            end
            check("tbl data", data, mw(vecs[v].addr));
        end
        idle(1);

        // Memory stalls the second issue for three cycles
        do_reset();
        stall_at   = 1;
        stall_left = 3;
        do_read(32'h0, -1, waits, data);
        check("stall waits", waits, 32'(LINE_WORDS + 2 + 3));
        check_refill("stall", 32'h0, 1);
        check("stall cycles", stall_log.size(), 32'h3);
        for (int k = 0; k < stall_log.size(); k++)
            check("stall held addr", stall_log[k], 32'h4);
        check("stall data", data, mw(32'h0));
        stall_at   = -1;
        stall_left = 0;

        // Invalidate during a refill of 0x20: line comes back invalid
        do_reset();
        do_read(32'h20, 2, waits, data);
        check("inv refill waits", waits, 32'(2 * (LINE_WORDS + 2)));
        check_refill("inv refill", 32'h20, 2);
        check("inv refill data", data, mw(32'h20));
        do_read(32'h24, -1, waits, data);
        check("inv refill then hit", waits, 32'h0);
        // Invalidate in the same cycle as a hit
        do_read(32'h28, 0, waits, data);
        check("inv same-cycle hit waits", waits, 32'h0);
        check("inv same-cycle hit data", data, mw(32'h28));
        do_read(32'h2C, -1, waits, data);
        check("inv same-cycle then miss", waits, 32'(LINE_WORDS + 2));
        // Invalidate while idle
        do_read(32'h0, -1, waits, data);
        pulse_invalidate();
        do_read(32'h0, -1, waits, data);
        check("idle inv miss", waits, 32'(LINE_WORDS + 2));
        check_refill("idle inv", 32'h0, 1);
        check("idle inv data", data, mw(32'h0));
        idle(1);

        // Reset after two of four responses
        do_reset();
        ibus_if.read    = 1'b1;
        ibus_if.address = 32'h0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        rst          = 1'b1;
        ibus_if.read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort mem_read", 32'(mem_read), 32'h0);
        check("abort waitrequest", 32'(ibus_if.waitrequest), 32'h0);
        check("abort readdata", ibus_if.readdata, 32'h0);
        idle(4);
        do_read(32'h0, -1, waits, data);
        check("abort re-miss waits", waits, 32'(LINE_WORDS + 2));
        check_refill("abort re-miss", 32'h0, 1);
        check("abort re-miss data", data, mw(32'h0));
        idle(1);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < NUM_LINES; i++) model_vld[i] = 1'b0;
        rnd_mode = 1'b1;
        for (int it = 0; it < 200; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                pulse_invalidate();
                for (int i = 0; i < NUM_LINES; i++) model_vld[i] = 1'b0;
            end else if (r == 1) begin
                ibus_if.read    = 1'b0;
                ibus_if.write   = 1'b1;
                ibus_if.address = $urandom;
                #1;
                check("rnd write waitrequest", 32'(ibus_if.waitrequest), 32'h0);
                @(negedge clk);
                ibus_if.write = 1'b0;
            end else begin
                a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4) |
                    (32'($urandom_range(0, 3)) << 2);
                b = line_base(a);
                exp_hit = model_vld[line_idx(a)] && (model_base[line_idx(a)] == b);
                do_read(a, -1, waits, data);
                if (exp_hit) begin
                    check("rnd hit waits", waits, 32'h0);
                end else begin
                    check("rnd miss stalled", 32'(waits > 0), 32'h1);
                    check_refill("rnd miss", b, 1);
                    model_vld[line_idx(a)]  = 1'b1;
                    model_base[line_idx(a)] = b;
                end
                check("rnd data", data, mw(a));
                if (r == 2) idle(int'($urandom_range(1, 3)));
            end
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
